// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers (one bit per cycle, WIDTH cycles).
// Define SIGNED_OPS_EN to honour signed_op for two's-complement MULT/DIV.
module mul_div_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  state_t state, state_next;

  logic             accept, last;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic [WIDTH-1:0] w_hi, w_lo, opnd;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   sum, sh;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [WIDTH-1:0] res_hi, res_lo;

`ifdef SIGNED_OPS_EN
  logic             a_neg, b_neg, neg_q, neg_r;
  logic [WIDTH-1:0] a_orig;
  logic [2*WIDTH-1:0] prod;

  assign a_neg = signed_op & a[WIDTH-1];
  assign b_neg = signed_op & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      a_orig <= '0;
    end else if (accept) begin
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      a_orig <= a;
    end
  end
`else
  logic unused_signed_op;
  assign unused_signed_op = signed_op;
  assign a_mag = a;
  assign b_mag = b;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: if (start && (op == OP_MULT || op == OP_DIV)) begin
        accept     = 1'b1;
        state_next = RUN;
      end
      RUN: if (cnt == LAST_CNT) begin
        last       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // One iteration: MULT shifts {w_hi,w_lo} right after a conditional add;
  // DIV shifts the dividend into the remainder and subtracts when it fits.
  always_comb begin
    sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, opnd} : '0);
    sh  = {w_hi, w_lo[WIDTH-1]};
    if (is_div) begin
      if (sh >= {1'b0, opnd}) begin
        step_hi = WIDTH'(sh - {1'b0, opnd});
        step_lo = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = WIDTH'(sh);
        step_lo = {w_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      step_hi = sum[WIDTH:1];
      step_lo = {sum[0], w_lo[WIDTH-1:1]};
    end
  end

  // Unsigned divide-by-zero falls out of the recurrence as hi=a, lo=all ones.
  always_comb begin
    res_hi = step_hi;
    res_lo = step_lo;
`ifdef SIGNED_OPS_EN
    prod = {step_hi, step_lo};
    if (is_div) begin
      if (opnd == '0) begin
        res_hi = a_orig;
        res_lo = '1;
      end else begin
        if (neg_q) res_lo = -step_lo;
        if (neg_r) res_hi = -step_hi;
      end
    end else if (neg_q) begin
      prod = -prod;
      {res_hi, res_lo} = prod;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      cnt         <= '0;
      is_div      <= 1'b0;
      w_hi        <= '0;
      w_lo        <= '0;
      opnd        <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        is_div      <= (op == OP_DIV);
        opnd        <= b_mag;
        w_hi        <= '0;
        w_lo        <= a_mag;
        cnt         <= '0;
        busy        <= 1'b1;
        div_by_zero <= 1'b0;
      end else if (state == RUN) begin
        w_hi <= step_hi;
        w_lo <= step_lo;
        cnt  <= cnt + 1'b1;
        if (last) begin
          hi          <= res_hi;
          lo          <= res_lo;
          done        <= 1'b1;
          busy        <= 1'b0;
          div_by_zero <= is_div && (opnd == '0);
        end
      end else if (start) begin
        if (op == OP_MTHI)      hi <= a;
        else if (op == OP_MTLO) lo <= a;
      end
    end
  end
endmodule
